// File: rtl/ahb3lite_switch_arbiter_pkg.sv
// Shared AHB3-Lite types and arbiter enums for the multi-layer switch.
package ahb3lite_switch_arbiter_pkg;

  typedef logic [1:0] htrans_t;

  localparam htrans_t HTRANS_IDLE   = 2'b00;
  localparam htrans_t HTRANS_BUSY   = 2'b01;
  localparam htrans_t HTRANS_NONSEQ = 2'b10;
  localparam htrans_t HTRANS_SEQ    = 2'b11;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  typedef enum logic [1:0] {
    NOOWNER = 2'd0,
    OWNED   = 2'd1,
    LOCKED  = 2'd2
  } arb_state_t;

  // True for transfers that actually move data (NONSEQ/SEQ).
  function automatic logic htrans_active(htrans_t t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb3lite_switch_arbiter_if.sv
// Request/grant bundle between the switch masters and one slave-port arbiter.
interface ahb3lite_switch_arbiter_if #(
  parameter int unsigned MASTERS       = 3,
  parameter int unsigned PRIORITY_BITS = 3
);
  localparam int unsigned IdxW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  logic [MASTERS-1:0]                    mst_req;
  logic [MASTERS-1:0][PRIORITY_BITS-1:0] mst_priority;
  logic [MASTERS-1:0][1:0]               mst_HTRANS;
  logic [MASTERS-1:0]                    mst_HMASTLOCK;
  logic [MASTERS-1:0]                    can_switch;
  logic                                  slv_HREADY;
  logic [MASTERS-1:0]                    grant;
  logic [IdxW-1:0]                       grant_idx;
  logic [IdxW-1:0]                       dp_master;
  logic                                  dp_valid;
  logic                                  hold_expired;

  // Arbiter side.
  modport slave (
    input  mst_req, mst_priority, mst_HTRANS, mst_HMASTLOCK, can_switch, slv_HREADY,
    output grant, grant_idx, dp_master, dp_valid, hold_expired
  );

  // Requesting side.
  modport master (
    output mst_req, mst_priority, mst_HTRANS, mst_HMASTLOCK, can_switch, slv_HREADY,
    input  grant, grant_idx, dp_master, dp_valid, hold_expired
  );

endinterface

// File: rtl/ahb3lite_switch_arbiter_pick.sv
// Combinational winner selection: highest priority, ties broken by index order
// (fixed) or by the first candidate after the round-robin pointer.
module ahb3lite_switch_arbiter_pick
  import ahb3lite_switch_arbiter_pkg::*;
#(
  parameter int unsigned MASTERS       = 3,
  parameter int unsigned PRIORITY_BITS = 3,
  localparam int unsigned IdxW         = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
  input  logic [MASTERS-1:0]                    cand_i,
  input  logic [MASTERS-1:0][PRIORITY_BITS-1:0] prio_i,
  input  logic [IdxW-1:0]                       rr_ptr_i,
  input  arb_mode_t                             mode_i,
  output logic [MASTERS-1:0]                    win_oh_o,
  output logic [IdxW-1:0]                       win_idx_o,
  output logic                                  valid_o
);

  // Scan in tie-break order; a strictly greater priority replaces the winner,
  // so the first candidate of the top class in scan order survives.
  always_comb begin
    int unsigned              idx;
    logic                     found;
    logic [PRIORITY_BITS-1:0] best;
    idx       = 0;
    found     = 1'b0;
    best      = '0;
    win_oh_o  = '0;
    win_idx_o = '0;
    for (int unsigned k = 0; k < MASTERS; k++) begin
      if (mode_i == ARB_RR) begin
        idx = 32'(rr_ptr_i) + 32'd1 + k;
        if (idx >= MASTERS) idx = idx - MASTERS;
      end else begin
        idx = k;
      end
      if (cand_i[idx] && (!found || (prio_i[idx] > best))) begin
        found     = 1'b1;
        best      = prio_i[idx];
        win_idx_o = IdxW'(idx);
      end
    end
    if (found) win_oh_o[win_idx_o] = 1'b1;
    valid_o = found;
  end

endmodule

// File: rtl/ahb3lite_switch_arbiter.sv
// Per-slave-port arbiter: address-phase ownership with lock, round-robin and
// anti-starvation hold limit, plus data-phase owner tracking.
module ahb3lite_switch_arbiter
  import ahb3lite_switch_arbiter_pkg::*;
#(
  parameter int unsigned MASTERS       = 3,
  parameter int unsigned PRIORITY_BITS = 3,
  parameter int unsigned ARB_MODE      = 1,
  parameter int unsigned HOLD_LIMIT    = 16
) (
  input logic                 HCLK,
  input logic                 HRESETn,
  ahb3lite_switch_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int unsigned CntW = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [IdxW-1:0] RrReset = IdxW'(MASTERS - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(HOLD_LIMIT);
  localparam arb_mode_t ArbMode = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_t         state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [IdxW-1:0]    rr_q, rr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [IdxW-1:0]    dp_master_q, dp_master_d;
  logic               dp_valid_q, dp_valid_d;

  htrans_t            owner_htrans;
  logic               owner_lock;
  logic               owner_may_switch;
  logic               owner_xfer;
  logic               others_req;
  logic               hold_exp;
  logic [MASTERS-1:0] cand;
  logic               arb_en;

  logic [MASTERS-1:0] pick_oh;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_valid;

  // Owner-side view of the bus and the candidate set offered to the picker.
  always_comb begin
    owner_htrans     = bus.mst_HTRANS[idx_q];
    owner_lock       = bus.mst_HMASTLOCK[idx_q];
    owner_may_switch = bus.can_switch[idx_q] || !bus.mst_req[idx_q];
    owner_xfer       = (state_q != NOOWNER) && htrans_active(owner_htrans);
    others_req       = |(bus.mst_req & ~grant_q);
    hold_exp         = (HOLD_LIMIT != 0) && (cnt_q == CntMax);
    cand             = bus.mst_req;
    // Expired owner steps aside only if someone else is actually waiting.
    if (hold_exp && others_req) cand = bus.mst_req & ~grant_q;
  end

  ahb3lite_switch_arbiter_pick #(
    .MASTERS       (MASTERS),
    .PRIORITY_BITS (PRIORITY_BITS)
  ) u_pick (
    .cand_i    (cand),
    .prio_i    (bus.mst_priority),
    .rr_ptr_i  (rr_q),
    .mode_i    (ArbMode),
    .win_oh_o  (pick_oh),
    .win_idx_o (pick_idx),
    .valid_o   (pick_valid)
  );

  // Next state: ownership, lock, round-robin pointer, hold counter, data phase.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    dp_master_d = dp_master_q;
    dp_valid_d  = dp_valid_q;
    arb_en      = 1'b0;
    if (bus.slv_HREADY) begin
      unique case (state_q)
        NOOWNER: arb_en = |bus.mst_req;
        OWNED: begin
          // Lock beats a simultaneous can_switch.
          if (owner_lock && (owner_htrans != HTRANS_IDLE)) state_d = LOCKED;
          else                                             arb_en  = owner_may_switch;
        end
        LOCKED: begin
          if (!owner_lock || (owner_htrans == HTRANS_IDLE)) begin
            state_d = OWNED;
            arb_en  = owner_may_switch;
          end
        end
        default: state_d = NOOWNER;
      endcase

      // No candidate leaves the current owner parked.
      if (arb_en && pick_valid) begin
        grant_d = pick_oh;
        idx_d   = pick_idx;
        rr_d    = pick_idx;
        state_d = OWNED;
      end

      if (grant_d != grant_q)     cnt_d = '0;
      else if (state_q == LOCKED) cnt_d = cnt_q;
      else if (!others_req)       cnt_d = '0;
      else if (owner_xfer && (cnt_q != CntMax)) cnt_d = cnt_q + 1'b1;

      dp_master_d = idx_q;
      dp_valid_d  = owner_xfer;
    end
  end

  // State register; reset drops ownership immediately, even mid-burst.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= NOOWNER;
      grant_q     <= '0;
      idx_q       <= '0;
      rr_q        <= RrReset;
      cnt_q       <= '0;
      dp_master_q <= '0;
      dp_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      idx_q       <= idx_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      dp_master_q <= dp_master_d;
      dp_valid_q  <= dp_valid_d;
    end
  end

  // Outputs straight from registers.
  always_comb begin
    bus.grant        = grant_q;
    bus.grant_idx    = idx_q;
    bus.dp_master    = dp_master_q;
    bus.dp_valid     = dp_valid_q;
    bus.hold_expired = hold_exp;
  end

endmodule

// File: tb/tb_ahb3lite_switch_arbiter.sv
// Bench: fixed-priority and round-robin arbiters driven in parallel, checked
// every cycle against a behavioural ownership model, plus directed scenarios.
module tb_ahb3lite_switch_arbiter;

  localparam int M   = 3;
  localparam int PB  = 3;
  localparam int LIM = 4;

  logic HCLK = 1'b0;
  logic HRESETn;
  always #5 HCLK = ~HCLK;

  logic [M-1:0]         req, lock, sw;
  logic [M-1:0][PB-1:0] prio;
  logic [M-1:0][1:0]    htrans;
  logic                 hready;

  ahb3lite_switch_arbiter_if #(.MASTERS(M), .PRIORITY_BITS(PB)) bus_fx ();
  ahb3lite_switch_arbiter_if #(.MASTERS(M), .PRIORITY_BITS(PB)) bus_rr ();

  assign bus_fx.mst_req       = req;
  assign bus_fx.mst_priority  = prio;
  assign bus_fx.mst_HTRANS    = htrans;
  assign bus_fx.mst_HMASTLOCK = lock;
  assign bus_fx.can_switch    = sw;
  assign bus_fx.slv_HREADY    = hready;
  assign bus_rr.mst_req       = req;
  assign bus_rr.mst_priority  = prio;
  assign bus_rr.mst_HTRANS    = htrans;
  assign bus_rr.mst_HMASTLOCK = lock;
  assign bus_rr.can_switch    = sw;
  assign bus_rr.slv_HREADY    = hready;

  ahb3lite_switch_arbiter #(
    .MASTERS(M), .PRIORITY_BITS(PB), .ARB_MODE(0), .HOLD_LIMIT(LIM)
  ) u_dut_fx (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus_fx)
  );

  ahb3lite_switch_arbiter #(
    .MASTERS(M), .PRIORITY_BITS(PB), .ARB_MODE(1), .HOLD_LIMIT(LIM)
  ) u_dut_rr (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus_rr)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per DUT: index 0 = fixed priority, 1 = round-robin.
  int m_own[2];   // -1 = no owner
  int m_lock[2];
  int m_rr[2];
  int m_cnt[2];
  int m_dpm[2];
  int m_dpv[2];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d] = -1; m_lock[d] = 0; m_rr[d] = M - 1;
      m_cnt[d] = 0;  m_dpm[d]  = 0; m_dpv[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int own, nxt, best_p, idx;
    bit others, xfer, arb, lk;
    bit [M-1:0] cand;
    if (!hready) return;
    own = m_own[d]; nxt = own; arb = 0; lk = (m_lock[d] != 0);
    others = 0; xfer = 0;
    for (int i = 0; i < M; i++) if (req[i] && i != own) others = 1;
    if (own >= 0) xfer = (htrans[own] == 2'b10) || (htrans[own] == 2'b11);
    if (own < 0) begin
      arb = (req != 0);
    end else if (!lk) begin
      if (lock[own] && htrans[own] != 2'b00) lk = 1;
      else arb = sw[own] || !req[own];
    end else if (!lock[own] || htrans[own] == 2'b00) begin
      lk  = 0;
      arb = sw[own] || !req[own];
    end
    if (arb) begin
      cand = req;
      if (own >= 0 && m_cnt[d] == LIM && others) cand[own] = 1'b0;
      best_p = -1;
      for (int i = 0; i < M; i++) if (cand[i] && int'(prio[i]) > best_p) best_p = int'(prio[i]);
      for (int k = 0; k < M; k++) begin
        idx = (d == 1) ? (m_rr[d] + 1 + k) % M : k;
        if (best_p >= 0 && cand[idx] && int'(prio[idx]) == best_p) begin
          nxt = idx; m_rr[d] = idx;
          break;
        end
      end
    end
    if (nxt != own)               m_cnt[d] = 0;
    else if (m_lock[d] != 0)      m_cnt[d] = m_cnt[d];
    else if (!others)             m_cnt[d] = 0;
    else if (xfer && m_cnt[d] < LIM) m_cnt[d]++;
    m_dpm[d]  = (own < 0) ? 0 : own;
    m_dpv[d]  = xfer ? 1 : 0;
    m_own[d]  = nxt;
    m_lock[d] = lk ? 1 : 0;
  endtask

  task automatic check_one(input string nm, input int d, input logic [M-1:0] g,
                           input logic [1:0] gi, input logic [1:0] dm, input logic dv,
                           input logic he);
    check({nm, ".grant"}, int'(g), (m_own[d] < 0) ? 0 : (1 << m_own[d]));
    check({nm, ".grant_idx"}, int'(gi), (m_own[d] < 0) ? 0 : m_own[d]);
    check({nm, ".dp_master"}, int'(dm), m_dpm[d]);
    check({nm, ".dp_valid"}, int'(dv), m_dpv[d]);
    check({nm, ".hold_expired"}, int'(he), (m_cnt[d] == LIM) ? 1 : 0);
  endtask

  task automatic check_all();
    check_one("fx", 0, bus_fx.grant, bus_fx.grant_idx, bus_fx.dp_master,
              bus_fx.dp_valid, bus_fx.hold_expired);
    check_one("rr", 1, bus_rr.grant, bus_rr.grant_idx, bus_rr.dp_master,
              bus_rr.dp_valid, bus_rr.hold_expired);
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    @(posedge HCLK);
    if (HRESETn) begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_all();
    @(negedge HCLK);
  endtask

  task automatic clear_inputs();
    req = '0; lock = '0; sw = '0; prio = '0; htrans = '0; hready = 1'b1;
  endtask

  // Asynchronous reset asserted mid-cycle, held n edges, released at a negedge.
  task automatic do_reset(input int n);
    HRESETn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge HCLK);
    for (int i = 0; i < n; i++) cycle();
    HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge HCLK);

    // Reset / idle, then first grant one cycle after release.
    do_reset(3);
    check("reset.grant", int'(bus_fx.grant), 0);
    check("reset.dp_valid", int'(bus_fx.dp_valid), 0);
    req = 3'b010; htrans[1] = 2'b10;
    cycle();
    check("first.grant", int'(bus_rr.grant), 3'b010);
    check("first.grant_idx", int'(bus_rr.grant_idx), 1);

    // Fixed priority: tie at 5 goes to lowest index, then m2 when m1 drops.
    prio[0] = 3'd2; prio[1] = 3'd5; prio[2] = 3'd5;
    req = 3'b111; sw = 3'b111; htrans = {2'b10, 2'b10, 2'b10};
    cycle();
    check("fixed.tie", int'(bus_fx.grant), 3'b010);
    prio[1] = 3'd1;
    cycle();
    check("fixed.prio", int'(bus_fx.grant), 3'b100);

    // Wait states hold everything; data phase catches up on HREADY.
    hready = 1'b0; sw = 3'b000;
    for (int i = 0; i < 4; i++) begin
      req = M'($urandom);
      cycle();
    end
    req = 3'b111; hready = 1'b1;
    cycle();
    check("wait.dp_master", int'(bus_fx.dp_master), 2);

    // Round-robin among equal priorities.
    clear_inputs();
    do_reset(2);
    prio = {3'd3, 3'd3, 3'd3}; req = 3'b111; sw = 3'b111;
    htrans = {2'b10, 2'b10, 2'b10};
    cycle(); check("rr.g0", int'(bus_rr.grant), 3'b001);
    cycle(); check("rr.g1", int'(bus_rr.grant), 3'b010);
    cycle(); check("rr.g2", int'(bus_rr.grant), 3'b100);
    cycle(); check("rr.g3", int'(bus_rr.grant), 3'b001);

    // Lock held across can_switch, released to the high-priority waiter.
    clear_inputs();
    do_reset(2);
    req = 3'b001; htrans[0] = 2'b10;
    cycle();
    lock[0] = 1'b1; req = 3'b101; sw = 3'b111; prio[2] = 3'd7;
    htrans[2] = 2'b10;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("lock.hold", int'(bus_rr.grant), 3'b001);
    end
    lock[0] = 1'b0;
    cycle();
    check("lock.release", int'(bus_rr.grant), 3'b100);

    // Starvation: high-priority streamer yields after LIM beats.
    clear_inputs();
    do_reset(2);
    prio[1] = 3'd7; prio[0] = 3'd1; req = 3'b010; htrans[1] = 2'b10;
    cycle();
    req = 3'b011; htrans[1] = 2'b11; htrans[0] = 2'b10;
    for (int i = 0; i < LIM; i++) begin
      if (i == LIM - 1) check("starve.not_yet", int'(bus_fx.hold_expired), 0);
      cycle();
    end
    check("starve.expired", int'(bus_fx.hold_expired), 1);
    sw = 3'b010;
    cycle();
    check("starve.switch", int'(bus_fx.grant), 3'b001);
    check("starve.clear", int'(bus_fx.hold_expired), 0);

    // Randomised traffic with wait states, locks and occasional resets.
    clear_inputs();
    for (int n = 0; n < 2000; n++) begin
      req    = M'($urandom);
      sw     = M'($urandom);
      hready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < M; i++) begin
        prio[i]   = ($urandom_range(0, 1) != 0) ? PB'(3) : PB'($urandom_range(0, 7));
        htrans[i] = 2'($urandom_range(0, 3));
        lock[i]   = ($urandom_range(0, 5) == 0);
      end
      if ($urandom_range(0, 299) == 0) do_reset(1);
      else cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
